// File: rtl/gestor_necesidades.sv
// gestor_necesidades: per-channel need levels with tick-driven decay, care
// buttons, a NORMAL/TEST mode FSM, long-press test entry and soft reset.
// Optional feature macro SLEEP_REGEN_EN: adds a sleep FSM that freezes
// decay of the energy channel and regenerates it while asleep.
module gestor_necesidades #(
  parameter int N_NEEDS     = 5,
  parameter int LVL_W       = 3,
  parameter int LVL_INIT    = 6,
  parameter int THRESH      = 5,
  parameter int PER_W       = 10,
  parameter int HOLD_CYCLES = 250000000,
  parameter int ENERGY_IDX  = 2,
  parameter int REGEN_TICKS = 60
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic [N_NEEDS*PER_W-1:0]   periodo,
  input  logic [N_NEEDS-1:0]         act,
  input  logic [N_NEEDS-1:0]         boost,
  input  logic                       sleep_req,
  input  logic                       wake_block,
  input  logic                       test_btn,
  input  logic                       reset_btn,
  input  logic [N_NEEDS*LVL_W-1:0]   test_lvls,
  output logic [N_NEEDS*LVL_W-1:0]   niveles,
  output logic [N_NEEDS-1:0]         alerta,
  output logic                       dormido,
  output logic                       modo_test
);
  localparam int LVL_MAX = (1 << LVL_W) - 1;
  localparam int SW      = LVL_W + 2;
  localparam int HW      = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0]    HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0]    HOLD_SAT   = HW'(HOLD_CYCLES);
  localparam logic [LVL_W-1:0] LVL_MAX_L  = LVL_W'(LVL_MAX);
  localparam logic [LVL_W-1:0] LVL_INIT_L = LVL_W'(LVL_INIT);
  localparam logic [LVL_W-1:0] THR_L      = LVL_W'(THRESH);

  typedef enum logic {NORMAL, TEST} mode_t;

  mode_t r_mode, w_mode_nx;

  logic                 r_tick_q, r_sleep_q, r_test_q;
  logic [N_NEEDS-1:0]   r_act_q;
  logic [HW-1:0]        r_test_hold, r_rst_hold;

  logic                 w_tick_ev, w_test_ev, w_test_long, w_srst, w_load;
  logic                 w_normal, w_asleep, w_regen_step;
  logic [N_NEEDS-1:0]   w_act_ev;

  logic [N_NEEDS-1:0][PER_W-1:0] w_per;
  logic [N_NEEDS-1:0][LVL_W-1:0] w_tl;
  logic [N_NEEDS-1:0][LVL_W-1:0] w_lvl;

  assign w_per = periodo;
  assign w_tl  = test_lvls;

  assign w_tick_ev = tick & ~r_tick_q;
  assign w_test_ev = test_btn & ~r_test_q;
  assign w_act_ev  = act & ~r_act_q;

  // A long press fires exactly once, on the clock that completes HOLD_CYCLES
  assign w_test_long = test_btn  && (r_test_hold == HOLD_LAST);
  assign w_srst      = reset_btn && (r_rst_hold  == HOLD_LAST);

  assign w_normal  = (r_mode == NORMAL);
  assign w_load    = (r_mode == TEST) && w_test_ev;
  assign modo_test = (r_mode == TEST);
  assign niveles   = w_lvl;

  // Previous-value registers for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst || w_srst) begin
      r_tick_q  <= 1'b0;
      r_sleep_q <= 1'b0;
      r_test_q  <= 1'b0;
      r_act_q   <= '0;
    end else begin
      r_tick_q  <= tick;
      r_sleep_q <= sleep_req;
      r_test_q  <= test_btn;
      r_act_q   <= act;
    end
  end

  // test_btn hold counter: clears on release, saturates while held
  always_ff @(posedge clk) begin
    if (rst || w_srst || !test_btn) r_test_hold <= '0;
    else if (r_test_hold != HOLD_SAT) r_test_hold <= r_test_hold + 1'b1;
  end

  // reset_btn hold counter: the soft reset leaves it saturated so a held
  // button cannot fire again until it is released
  always_ff @(posedge clk) begin
    if (rst || !reset_btn) r_rst_hold <= '0;
    else if (r_rst_hold != HOLD_SAT) r_rst_hold <= r_rst_hold + 1'b1;
  end

  // Mode FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_mode <= NORMAL;
    else     r_mode <= w_mode_nx;
  end

  // Mode FSM next state: long press enters TEST, only a reset leaves it
  always_comb begin
    w_mode_nx = r_mode;
    case (r_mode)
      NORMAL:  if (w_test_long) w_mode_nx = TEST;
      TEST:    w_mode_nx = TEST;
      default: w_mode_nx = NORMAL;
    endcase
    if (w_srst) w_mode_nx = NORMAL;
  end

`ifdef SLEEP_REGEN_EN
  localparam int RW = (REGEN_TICKS > 1) ? $clog2(REGEN_TICKS) : 1;
  localparam logic [RW-1:0] RLAST = RW'(REGEN_TICKS - 1);

  typedef enum logic {DESPIERTO, DORMIDO} sleep_t;

  sleep_t        r_sleep, w_sleep_nx;
  logic [RW-1:0] r_regen;
  logic          w_sleep_ev, w_others_ok;

  assign w_sleep_ev   = sleep_req & ~r_sleep_q;
  assign w_asleep     = (r_sleep == DORMIDO);
  assign w_regen_step = w_asleep && w_tick_ev && w_normal && (r_regen == RLAST);
  assign dormido      = w_asleep;

  // True when every non-energy channel is at or above the healthy threshold
  always_comb begin
    w_others_ok = 1'b1;
    for (int i = 0; i < N_NEEDS; i++)
      if (i != ENERGY_IDX && w_lvl[i] < THR_L) w_others_ok = 1'b0;
  end

  // Sleep FSM next state
  always_comb begin
    w_sleep_nx = r_sleep;
    case (r_sleep)
      DESPIERTO: if (w_sleep_ev && w_normal && !wake_block && w_others_ok)
                   w_sleep_nx = DORMIDO;
      DORMIDO:   if (wake_block || !w_others_ok || w_lvl[ENERGY_IDX] == LVL_MAX_L)
                   w_sleep_nx = DESPIERTO;
      default:   w_sleep_nx = DESPIERTO;
    endcase
    if (w_load || w_srst) w_sleep_nx = DESPIERTO;
  end

  // Sleep FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_sleep <= DESPIERTO;
    else     r_sleep <= w_sleep_nx;
  end

  // Regeneration tick counter, cleared whenever the block is (or goes) awake
  always_ff @(posedge clk) begin
    if (rst || w_sleep_nx == DESPIERTO) r_regen <= '0;
    else if (w_asleep && w_tick_ev && w_normal)
      r_regen <= (r_regen == RLAST) ? '0 : r_regen + 1'b1;
  end
`else
  logic w_unused_sleep;
  assign w_unused_sleep = &{1'b0, r_sleep_q, wake_block};
  assign w_asleep       = 1'b0;
  assign w_regen_step   = 1'b0;
  assign dormido        = 1'b0;
`endif

  for (genvar i = 0; i < N_NEEDS; i++) begin : g_ch
    localparam bit IS_E = (i == ENERGY_IDX);

    logic [LVL_W-1:0] r_lvl;
    logic [PER_W-1:0] r_cnt;
    logic             w_frz, w_due, w_dec, w_act_ok, w_regen;
    logic [1:0]       w_inc;
    logic [SW-1:0]    w_up, w_dn;
    logic [LVL_W-1:0] w_new;

    // Energy neither decays nor advances its decay counter while asleep
    assign w_frz    = IS_E && w_asleep;
    assign w_due    = (w_per[i] != '0) && (r_cnt >= w_per[i] - PER_W'(1));
    assign w_dec    = w_tick_ev && w_normal && w_due && !w_frz;
    assign w_act_ok = w_act_ev[i] && w_normal && !w_asleep;
    assign w_inc    = w_act_ok ? (boost[i] ? 2'd2 : 2'd1) : 2'd0;
    assign w_regen  = IS_E && w_regen_step;

    // Increment first in a wider word, then decrement with floor and clamp
    assign w_up  = {2'b00, r_lvl} + SW'(w_inc) + SW'(w_regen);
    assign w_dn  = !w_dec ? w_up : ((w_up == '0) ? '0 : w_up - 1'b1);
    assign w_new = (w_dn > SW'(LVL_MAX)) ? LVL_MAX_L : w_dn[LVL_W-1:0];

    assign w_lvl[i]  = r_lvl;
    assign alerta[i] = (r_lvl < THR_L);

    // Level and decay counter for this channel
    always_ff @(posedge clk) begin
      if (rst || w_srst) begin
        r_lvl <= LVL_INIT_L;
        r_cnt <= '0;
      end else if (w_load) begin
        r_lvl <= w_tl[i];
      end else begin
        r_lvl <= w_new;
        if (w_act_ok)
          r_cnt <= '0;
        else if (w_tick_ev && w_normal && !w_frz)
          r_cnt <= (w_per[i] == '0 || w_due) ? '0 : r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gestor_necesidades.sv
// Bench for gestor_necesidades: table of tick/act vectors, then hand-written
// sequences for sleep, test mode, soft reset and reset during a long press.
module tb_gestor_necesidades;
  logic        clk = 1'b0;
  logic        rst, tick, sleep_req, wake_block, test_btn, reset_btn;
  logic [49:0] periodo;
  logic [4:0]  act, boost, alerta;
  logic [14:0] test_lvls, niveles;
  logic        dormido, modo_test;

  gestor_necesidades #(
    .N_NEEDS(5), .LVL_W(3), .LVL_INIT(6), .THRESH(5), .PER_W(10),
    .HOLD_CYCLES(8), .ENERGY_IDX(2), .REGEN_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .periodo(periodo), .act(act),
    .boost(boost), .sleep_req(sleep_req), .wake_block(wake_block),
    .test_btn(test_btn), .reset_btn(reset_btn), .test_lvls(test_lvls),
    .niveles(niveles), .alerta(alerta), .dormido(dormido), .modo_test(modo_test)
  );

  always #5 clk = ~clk;

  typedef struct { string name; logic [14:0] niv; logic dorm; logic mt; } exp_t;
  typedef struct { logic tk; logic [4:0] a; logic [4:0] b; logic [14:0] niv; } vec_t;

  exp_t        q[$];
  vec_t        tv[22];
  int          n_chk = 0, n_fail = 0;
  logic [14:0] cur;

  function automatic logic [14:0] pk(int l0, int l1, int l2, int l3, int l4);
    return {3'(l4), 3'(l3), 3'(l2), 3'(l1), 3'(l0)};
  endfunction

  function automatic logic [4:0] al_of(logic [14:0] v);
    logic [4:0] a;
    for (int i = 0; i < 5; i++) a[i] = (v[i*3 +: 3] < 3'd5);
    return a;
  endfunction

  function automatic vec_t mk(logic tk, logic [4:0] a, logic [4:0] b, logic [14:0] niv);
    vec_t v;
    v.tk = tk; v.a = a; v.b = b; v.niv = niv;
    return v;
  endfunction

  task automatic clk1();
    @(posedge clk); #1;
  endtask

  task automatic push(string nm, logic [14:0] v, logic d, logic m);
    exp_t e;
    e.name = nm; e.niv = v; e.dorm = d; e.mt = m;
    q.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    logic [21:0] got, want;
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty");
      return;
    end
    e = q.pop_front();
    got  = {niveles, alerta, dormido, modo_test};
    want = {e.niv, al_of(e.niv), e.dorm, e.mt};
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got niv=%h al=%b dorm=%b mt=%b, want niv=%h al=%b dorm=%b mt=%b",
               e.name, niveles, alerta, dormido, modo_test, e.niv, al_of(e.niv), e.dorm, e.mt);
    end
  endtask

  task automatic tick_ev();
    tick = 1'b1; clk1(); tick = 1'b0; clk1();
  endtask

  task automatic press(logic [4:0] a, logic [4:0] b);
    act = a; boost = b; clk1(); act = '0; boost = '0; clk1();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick = 0; sleep_req = 0; wake_block = 0; test_btn = 0; reset_btn = 0;
    act = '0; boost = '0; test_lvls = '0;
    periodo = '0;
    periodo[9:0] = 10'd3;

    tv[0]  = mk(1, 5'b00000, 5'b00000, pk(6,6,6,6,6));
    tv[1]  = mk(1, 5'b00000, 5'b00000, pk(6,6,6,6,6));
    tv[2]  = mk(1, 5'b00000, 5'b00000, pk(5,6,6,6,6));
    tv[3]  = mk(1, 5'b00000, 5'b00000, pk(5,6,6,6,6));
    tv[4]  = mk(1, 5'b00000, 5'b00000, pk(5,6,6,6,6));
    tv[5]  = mk(1, 5'b00000, 5'b00000, pk(4,6,6,6,6));
    tv[6]  = mk(0, 5'b00010, 5'b00010, pk(4,7,6,6,6));
    tv[7]  = mk(0, 5'b00010, 5'b00010, pk(4,7,6,6,6));
    tv[8]  = mk(0, 5'b00001, 5'b00000, pk(5,7,6,6,6));
    tv[9]  = mk(1, 5'b00000, 5'b00000, pk(5,7,6,6,6));
    tv[10] = mk(1, 5'b00000, 5'b00000, pk(5,7,6,6,6));
    tv[11] = mk(1, 5'b00001, 5'b00000, pk(5,7,6,6,6));
    tv[12] = mk(1, 5'b00000, 5'b00000, pk(5,7,6,6,6));
    tv[13] = mk(1, 5'b00000, 5'b00000, pk(5,7,6,6,6));
    tv[14] = mk(1, 5'b00000, 5'b00000, pk(4,7,6,6,6));
    tv[15] = mk(1, 5'b00000, 5'b00000, pk(4,7,6,6,6));
    tv[16] = mk(1, 5'b00001, 5'b00000, pk(5,7,6,6,6));
    tv[17] = mk(1, 5'b00000, 5'b00000, pk(5,7,6,6,6));
    tv[18] = mk(1, 5'b00000, 5'b00000, pk(5,7,6,6,6));
    tv[19] = mk(1, 5'b00000, 5'b00000, pk(4,7,6,6,6));
    tv[20] = mk(0, 5'b10000, 5'b00000, pk(4,7,6,6,7));
    tv[21] = mk(0, 5'b00000, 5'b11111, pk(4,7,6,6,7));

    // Reset state
    repeat (2) clk1();
    push("reset", pk(6,6,6,6,6), 1'b0, 1'b0);
    rst = 1'b0;
    pop_chk();

    // Decay / care table: each vector is one driven clock plus one release clock
    for (int k = 0; k < 22; k++) begin
      tick = tv[k].tk; act = tv[k].a; boost = tv[k].b;
      push($sformatf("vec%0d", k), tv[k].niv, 1'b0, 1'b0);
      clk1(); pop_chk();
      tick = 1'b0; act = '0; boost = '0;
      push($sformatf("vec%0d_rel", k), tv[k].niv, 1'b0, 1'b0);
      clk1(); pop_chk();
    end

    // Raise channel 0, then drain energy to 4
    push("boost_ch0", pk(6,7,6,6,7), 1'b0, 1'b0);
    press(5'b00001, 5'b00001); pop_chk();
    periodo[29:20] = 10'd1;
    push("energy_to_4", pk(6,7,4,6,7), 1'b0, 1'b0);
    tick_ev(); tick_ev(); pop_chk();

`ifdef SLEEP_REGEN_EN
    sleep_req = 1'b1;
    push("sleep_enter", pk(6,7,4,6,7), 1'b1, 1'b0);
    clk1(); pop_chk();
    sleep_req = 1'b0; clk1();
    push("act_while_asleep", pk(6,7,4,6,7), 1'b1, 1'b0);
    press(5'b01000, 5'b00000); pop_chk();
    push("regen", pk(5,7,5,6,7), 1'b1, 1'b0);
    tick_ev(); tick_ev(); pop_chk();
    wake_block = 1'b1;
    push("wake", pk(5,7,5,6,7), 1'b0, 1'b0);
    clk1(); pop_chk();
    wake_block = 1'b0;
    cur = pk(5,7,5,6,7);
`else
    sleep_req = 1'b1;
    push("sleep_ignored", pk(6,7,4,6,7), 1'b0, 1'b0);
    clk1(); pop_chk();
    sleep_req = 1'b0; clk1();
    push("act_awake", pk(6,7,4,7,7), 1'b0, 1'b0);
    press(5'b01000, 5'b00000); pop_chk();
    push("energy_decays", pk(5,7,2,7,7), 1'b0, 1'b0);
    tick_ev(); tick_ev(); pop_chk();
    cur = pk(5,7,2,7,7);
`endif
    periodo[29:20] = 10'd0;

    // Long press into TEST
    test_btn = 1'b1;
    push("test_hold7", cur, 1'b0, 1'b0);
    repeat (7) clk1(); pop_chk();
    push("test_hold8", cur, 1'b0, 1'b1);
    clk1(); pop_chk();
    push("test_held_more", cur, 1'b0, 1'b1);
    repeat (5) clk1(); pop_chk();
    test_btn = 1'b0; clk1();
    push("test_tick_frozen", cur, 1'b0, 1'b1);
    tick_ev(); tick_ev(); tick_ev(); pop_chk();

    test_lvls = pk(2,2,2,2,2);
    test_btn = 1'b1;
    push("test_load_2", pk(2,2,2,2,2), 1'b0, 1'b1);
    clk1(); pop_chk();
    test_btn = 1'b0; clk1();
    push("test_act_frozen", pk(2,2,2,2,2), 1'b0, 1'b1);
    press(5'b00001, 5'b00001); pop_chk();
    test_lvls = pk(1,3,5,7,0);
    test_btn = 1'b1;
    push("test_load_mix", pk(1,3,5,7,0), 1'b0, 1'b1);
    clk1(); pop_chk();
    test_btn = 1'b0; clk1();

    // Soft reset long press, then no retrigger while still held
    reset_btn = 1'b1;
    push("srst_hold7", pk(1,3,5,7,0), 1'b0, 1'b1);
    repeat (7) clk1(); pop_chk();
    push("srst_hold8", pk(6,6,6,6,6), 1'b0, 1'b0);
    clk1(); pop_chk();
    push("srst_no_retrigger", pk(6,7,6,6,6), 1'b0, 1'b0);
    press(5'b00010, 5'b00000);
    repeat (10) clk1(); pop_chk();
    reset_btn = 1'b0; clk1();

    // rst in the middle of a long press restarts the hold count
    test_btn = 1'b1;
    repeat (7) clk1();
    rst = 1'b1;
    push("rst_mid_press", pk(6,6,6,6,6), 1'b0, 1'b0);
    clk1(); pop_chk();
    rst = 1'b0;
    push("after_rst_hold7", pk(6,6,6,6,6), 1'b0, 1'b0);
    repeat (7) clk1(); pop_chk();
    push("after_rst_hold8", pk(6,6,6,6,6), 1'b0, 1'b1);
    clk1(); pop_chk();
    test_btn = 1'b0;

    // Floor at 0 and same-cycle tick+act at the floor
    rst = 1'b1; clk1(); rst = 1'b0;
    periodo[9:0] = 10'd1;
    push("floor_zero", pk(0,6,6,6,6), 1'b0, 1'b0);
    repeat (7) tick_ev(); pop_chk();
    tick = 1'b1; act = 5'b00001;
    push("floor_tick_act", pk(0,6,6,6,6), 1'b0, 1'b0);
    clk1(); pop_chk();
    tick = 1'b0; act = '0; clk1();
    tick = 1'b1; act = 5'b00001; boost = 5'b00001;
    push("floor_tick_boost", pk(1,6,6,6,6), 1'b0, 1'b0);
    clk1(); pop_chk();
    tick = 1'b0; act = '0; boost = '0; clk1();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gestor_necesidades.md
GESTOR_NECESIDADES -- requirements
Module: gestor_necesidades

Interface
REQ-001 SHALL have parameter N_NEEDS, default 5, number of need channels.
REQ-002 SHALL have parameter LVL_W, default 3, level width; LVL_MAX = 2^LVL_W-1.
REQ-003 SHALL have parameter LVL_INIT, default 6, level after any reset.
REQ-004 SHALL have parameter THRESH, default 5, healthy threshold.
REQ-005 SHALL have parameter PER_W, default 10, decay-period width.
REQ-006 SHALL have parameter HOLD_CYCLES, default 250000000, long-press length in clocks.
REQ-007 SHALL have parameter ENERGY_IDX, default 2, energy channel index.
REQ-008 SHALL have parameter REGEN_TICKS, default 60, ticks per sleep regeneration step.
REQ-009 SHALL have the following ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  level-held 1 Hz flag; its rising edge is one tick.
- periodo  in  N_NEEDS*PER_W  per-channel decay period in ticks; 0 disables decay.
- act  in  N_NEEDS  per-channel care button, rising-edge active.
- boost  in  N_NEEDS  per-channel double-increment qualifier.
- sleep_req  in  1  sleep button.
- wake_block  in  1  sensor wake condition (light or proximity).
- test_btn  in  1  test button.
- reset_btn  in  1  soft-reset button.
- test_lvls  in  N_NEEDS*LVL_W  levels loaded in test mode.
- niveles  out  N_NEEDS*LVL_W  packed levels.
- alerta  out  N_NEEDS  level < THRESH.
- dormido  out  1  sleep state.
- modo_test  out  1  test mode active.

Function
REQ-010 SHALL edge-detect tick, act, sleep_req and test_btn with a registered previous value; one internal event per rising edge.
REQ-011 In NORMAL mode on a tick event, each channel SHALL behave as follows:
- periodo = 0: counter held at 0.
- counter >= periodo-1: counter cleared and level decremented, saturating at 0.
- otherwise: counter incremented.
REQ-012 An act[i] event in NORMAL mode while awake SHALL add 2 if boost[i] else 1, saturating at LVL_MAX, and clear counter i.
REQ-013 An act[i] event while dormido or in TEST mode SHALL be ignored; the edge is consumed.
REQ-014 If a tick and an act event hit the same channel in the same cycle, the result SHALL be level minus decrement plus increment, clamped to 0..LVL_MAX, with the counter cleared.
REQ-015 alerta[i] SHALL be combinational from the registered levels.
REQ-016 Mode FSM states SHALL be NORMAL and TEST.
- NORMAL to TEST: test_btn held high for HOLD_CYCLES consecutive clocks; the hold counter clears on any low cycle.
- TEST: decay and actions are frozen; each test_btn rising edge loads test_lvls into all levels and clears dormido.
- The rising edge that completes the long press SHALL NOT itself load test_lvls.
REQ-017 reset_btn held HOLD_CYCLES consecutive clocks, in either mode, SHALL perform a soft reset identical to rst, and SHALL take priority over all same-cycle events.
REQ-018 Long-press counters SHALL saturate and not wrap while the button stays held; a re-trigger requires release.
REQ-019 modo_test SHALL equal (state == TEST).

Reset
REQ-020 With rst high at a clk edge, the block SHALL set:
- every level to LVL_INIT and every counter to 0;
- mode to NORMAL, dormido to 0;
- all edge registers and hold counters to 0.
REQ-021 rst SHALL override all other inputs in the same cycle, including mid-long-press and mid-sleep.

Configuration
REQ-022 With macro SLEEP_REGEN_EN defined, a sleep FSM (DESPIERTO, DORMIDO) SHALL exist.
- Entry: a sleep_req event in NORMAL mode with wake_block = 0 and every level other than ENERGY_IDX >= THRESH.
- While DORMIDO, the energy channel SHALL NOT decay; it SHALL gain 1 every REGEN_TICKS ticks, saturating.
- Exit, on the next clk: wake_block = 1, any non-energy level < THRESH, or energy = LVL_MAX; the regen counter clears on exit.
REQ-023 Without SLEEP_REGEN_EN, dormido SHALL be constant 0, sleep_req SHALL be ignored, and the energy channel SHALL decay normally.

Verification
REQ-024 The bench SHALL cover these scenarios, with N_NEEDS=5, LVL_W=3, HOLD_CYCLES=8, periodo[0]=3, REGEN_TICKS=2:
- 3 tick edges -> level0 goes 6 to 5 on the 3rd edge; 6 ticks -> 4, alerta[0]=1.
- act[1] with boost[1]=1 at level 6 -> level1 = 7 (saturated); a second press -> still 7.
- Same-cycle tick (decrement due) and act[0] at level 5 -> level0 = 5, counter0 = 0.
- test_btn high 8 clocks -> modo_test=1; release then press with test_lvls all 2 -> all levels 2; reset_btn 8 clocks -> levels 6, modo_test=0.
- SLEEP_REGEN_EN, sleep_req with energy 4 -> dormido=1; 2 ticks -> energy 5; wake_block=1 -> dormido=0 next clock.
- rst asserted with test_btn held 7 clocks -> hold counter 0; releasing rst with test_btn still high requires 8 more clocks to enter TEST.
